// File: rtl/jtframe_dump_pkg.sv
// Shared definitions for the frame-synchronous dump trigger blocks.
// State encoding and default widths.
package jtframe_dump_pkg;

    localparam int unsigned DT_CW = 32;
    localparam int unsigned DT_LW = 16;

    typedef enum logic [1:0] {
        DT_IDLE   = 2'd0,
        DT_ARMED  = 2'd1,
        DT_ACTIVE = 2'd2,
        DT_DONE   = 2'd3
    } dt_state_e;

endpackage

// File: rtl/jtframe_dump_edge.sv
// Registers vertical sync and flags its falling edge (end of frame).
// vs_l resets low, keeping fall low during the first cycle after reset.
module jtframe_dump_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic vs,
    output logic vs_l,
    output logic fall
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_l <= 1'b0;
        end else begin
            vs_l <= vs;
        end
    end

    assign fall = vs_l & ~vs;

endmodule

// File: rtl/jtframe_dump_trig.sv
// Frame counter plus armable dump window: opens on a programmed frame and
// closes after a programmed number of frames (0 = until disarm/download).
module jtframe_dump_trig
    import jtframe_dump_pkg::*;
#(
    parameter int unsigned CW = DT_CW,
    parameter int unsigned LW = DT_LW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          vs,
    input  logic          dwn,
    input  logic          arm,
    input  logic          disarm,
    input  logic [CW-1:0] start_frame,
    input  logic [LW-1:0] len,
    output logic [CW-1:0] frame_cnt,
    output logic          dump_en,
    output logic          dump_start,
    output logic          dump_stop,
    output logic [1:0]    state
);

    dt_state_e     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] st_q;
    logic [LW-1:0] len_q, rem_q;
    logic          en_q, en_d;
    logic          start_q, start_d;
    logic          stop_q, stop_d;
    logic          vs_l, fall;
    logic          latch, open_win;

    jtframe_dump_edge u_edge (
        .clk   (clk),
        .rst_n (rst_n),
        .vs    (vs),
        .vs_l  (vs_l),
        .fall  (fall)
    );

    always_comb begin
        cnt_d = cnt_q;
        if (dwn) begin
            cnt_d = '0;
        end else if (fall) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= DT_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: disarm beats everything, download aborts a pending/open window
    always_comb begin
        state_d = state_q;
        if (disarm) begin
            state_d = DT_IDLE;
        end else if (dwn && (state_q == DT_ARMED || state_q == DT_ACTIVE)) begin
            state_d = DT_IDLE;
        end else begin
            case (state_q)
                DT_IDLE, DT_DONE: if (arm) state_d = DT_ARMED;
                DT_ARMED:         if (fall && cnt_q == st_q) state_d = DT_ACTIVE;
                DT_ACTIVE: begin
                    if (len_q != '0 && fall && rem_q == LW'(1)) state_d = DT_DONE;
                end
                default:          state_d = DT_IDLE;
            endcase
        end
    end

    // Output next values, registered below so no input reaches an output combinationally
    always_comb begin
        en_d    = (state_d == DT_ACTIVE);
        start_d = en_d && (state_q != DT_ACTIVE);
        stop_d  = (state_q == DT_ACTIVE) && !en_d;
    end

    assign latch    = arm && !disarm && (state_q == DT_IDLE || state_q == DT_DONE);
    assign open_win = (state_q == DT_ARMED) && (state_d == DT_ACTIVE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            st_q    <= '0;
            len_q   <= '0;
            rem_q   <= '0;
            en_q    <= 1'b0;
            start_q <= 1'b0;
            stop_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            en_q    <= en_d;
            start_q <= start_d;
            stop_q  <= stop_d;
            if (latch) begin
                st_q  <= start_frame;
                len_q <= len;
            end
            if (open_win) begin
                rem_q <= len_q;
            end else if (state_q == DT_ACTIVE && fall && len_q != '0) begin
                rem_q <= rem_q - LW'(1);
            end
        end
    end

    assign frame_cnt  = cnt_q;
    assign dump_en    = en_q;
    assign dump_start = start_q;
    assign dump_stop  = stop_q;
    assign state      = state_q;

endmodule

// File: tb/tb_jtframe_dump_trig.sv
// Directed bench for jtframe_dump_trig: a default-width instance and a CW=4
// instance share stimulus; the small one exercises counter wrap-around.
module tb_jtframe_dump_trig;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        vs = 1'b0, dwn = 1'b0, arm = 1'b0, disarm = 1'b0;
    logic [31:0] start_frame = '0;
    logic [3:0]  start4 = '0;
    logic [15:0] len = '0;
    logic [31:0] frame_cnt;
    logic [3:0]  frame_cnt4;
    logic        dump_en, dump_start, dump_stop;
    logic        dump_en4, dump_start4, dump_stop4;
    logic [1:0]  state, state4;

    int tests = 0, fails = 0;
    int n_start = 0, n_stop = 0, n_both = 0;
    logic [31:0] start_fc = '0, stop_fc = '0;

    always #5 clk = ~clk;

    jtframe_dump_trig #(.CW(32), .LW(16)) dut (
        .clk(clk), .rst_n(rst_n), .vs(vs), .dwn(dwn), .arm(arm), .disarm(disarm),
        .start_frame(start_frame), .len(len), .frame_cnt(frame_cnt), .dump_en(dump_en),
        .dump_start(dump_start), .dump_stop(dump_stop), .state(state)
    );

    jtframe_dump_trig #(.CW(4), .LW(16)) dut4 (
        .clk(clk), .rst_n(rst_n), .vs(vs), .dwn(dwn), .arm(arm), .disarm(disarm),
        .start_frame(start4), .len(len), .frame_cnt(frame_cnt4), .dump_en(dump_en4),
        .dump_start(dump_start4), .dump_stop(dump_stop4), .state(state4)
    );

    always @(negedge clk) begin
        if (dump_start) begin
            n_start++;
            start_fc = frame_cnt;
        end
        if (dump_stop) begin
            n_stop++;
            stop_fc = frame_cnt;
        end
        if (dump_start && dump_stop) n_both++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_mon();
        n_start = 0;
        n_stop  = 0;
        n_both  = 0;
    endtask

    task automatic frame();
        vs = 1'b1;
        tick();
        tick();
        vs = 1'b0;
        tick();
        tick();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        {vs, dwn, arm, disarm} = '0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        clr_mon();
    endtask

    task automatic arm_pulse(input logic [31:0] st, input logic [3:0] st4, input logic [15:0] l);
        start_frame = st;
        start4 = st4;
        len = l;
        arm = 1'b1;
        tick();
        arm = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        tests++; if (frame_cnt !== 32'd0) begin fails++; $display("FAIL reset_cnt: got %0d want 0", frame_cnt); end
        tests++; if (dump_en !== 1'b0) begin fails++; $display("FAIL reset_en: got %b want 0", dump_en); end
        tests++; if ({dump_start, dump_stop} !== 2'b00) begin fails++; $display("FAIL reset_pulses: got %b want 00", {dump_start, dump_stop}); end
        tests++; if (state !== 2'd0) begin fails++; $display("FAIL reset_state: got %0d want 0", state); end
        do_reset();
    endtask

    task automatic test_count();
        do_reset();
        repeat (5) frame();
        tests++; if (frame_cnt !== 32'd5) begin fails++; $display("FAIL count5: got %0d want 5", frame_cnt); end
        tests++; if (state !== 2'd0) begin fails++; $display("FAIL count_state: got %0d want 0", state); end
        tests++; if (n_start + n_stop !== 0) begin fails++; $display("FAIL count_pulses: got %0d want 0", n_start + n_stop); end
    endtask

    task automatic test_window();
        do_reset();
        arm_pulse(32'd3, 4'd3, 16'd2);
        tests++; if (state !== 2'd1) begin fails++; $display("FAIL win_armed: got %0d want 1", state); end
        repeat (3) frame();
        tests++; if (n_start !== 0 || dump_en !== 1'b0) begin fails++; $display("FAIL win_early: got start=%0d en=%b want 0/0", n_start, dump_en); end
        frame();
        tests++; if (n_start !== 1 || start_fc !== 32'd4) begin fails++; $display("FAIL win_open: got n=%0d fc=%0d want 1/4", n_start, start_fc); end
        tests++; if (dump_en !== 1'b1 || state !== 2'd2) begin fails++; $display("FAIL win_active: got en=%b st=%0d want 1/2", dump_en, state); end
        frame();
        tests++; if (dump_en !== 1'b1 || n_stop !== 0) begin fails++; $display("FAIL win_mid: got en=%b stops=%0d want 1/0", dump_en, n_stop); end
        frame();
        tests++; if (n_stop !== 1 || stop_fc !== 32'd6) begin fails++; $display("FAIL win_close: got n=%0d fc=%0d want 1/6", n_stop, stop_fc); end
        tests++; if (dump_en !== 1'b0 || state !== 2'd3) begin fails++; $display("FAIL win_done: got en=%b st=%0d want 0/3", dump_en, state); end
        tests++; if (n_both !== 0 || n_start !== 1) begin fails++; $display("FAIL win_excl: got both=%0d starts=%0d want 0/1", n_both, n_start); end
    endtask

    task automatic test_unlimited();
        do_reset();
        arm_pulse(32'd0, 4'd0, 16'd0);
        frame();
        tests++; if (n_start !== 1 || dump_en !== 1'b1) begin fails++; $display("FAIL unl_open: got n=%0d en=%b want 1/1", n_start, dump_en); end
        repeat (12) frame();
        tests++; if (dump_en !== 1'b1 || n_stop !== 0 || state !== 2'd2) begin fails++; $display("FAIL unl_hold: got en=%b stops=%0d st=%0d want 1/0/2", dump_en, n_stop, state); end
        arm_pulse(32'd5, 4'd5, 16'd1);
        tests++; if (state !== 2'd2) begin fails++; $display("FAIL unl_arm_ignored: got %0d want 2", state); end
        disarm = 1'b1;
        tick();
        disarm = 1'b0;
        tick();
        tests++; if (n_stop !== 1 || dump_en !== 1'b0 || state !== 2'd0) begin fails++; $display("FAIL unl_disarm: got stops=%0d en=%b st=%0d want 1/0/0", n_stop, dump_en, state); end
    endtask

    task automatic test_wrap();
        do_reset();
        repeat (14) frame();
        tests++; if (frame_cnt4 !== 4'd14) begin fails++; $display("FAIL wrap_pre: got %0d want 14", frame_cnt4); end
        arm_pulse(32'd1000, 4'd1, 16'd1);
        frame();
        frame();
        tests++; if (frame_cnt4 !== 4'd0 || state4 !== 2'd1) begin fails++; $display("FAIL wrap_zero: got fc=%0d st=%0d want 0/1", frame_cnt4, state4); end
        frame();
        tests++; if (state4 !== 2'd1 || dump_en4 !== 1'b0) begin fails++; $display("FAIL wrap_wait: got st=%0d en=%b want 1/0", state4, dump_en4); end
        frame();
        tests++; if (state4 !== 2'd2 || dump_en4 !== 1'b1 || frame_cnt4 !== 4'd2) begin fails++; $display("FAIL wrap_open: got st=%0d en=%b fc=%0d want 2/1/2", state4, dump_en4, frame_cnt4); end
        frame();
        tests++; if (state4 !== 2'd3 || dump_en4 !== 1'b0) begin fails++; $display("FAIL wrap_close: got st=%0d en=%b want 3/0", state4, dump_en4); end
    endtask

    task automatic test_dwn();
        do_reset();
        arm_pulse(32'd0, 4'd0, 16'd0);
        frame();
        clr_mon();
        dwn = 1'b1;
        tick();
        tests++; if (state !== 2'd0 || frame_cnt !== 32'd0 || dump_en !== 1'b0) begin fails++; $display("FAIL dwn_abort: got st=%0d fc=%0d en=%b want 0/0/0", state, frame_cnt, dump_en); end
        tick();
        tests++; if (n_stop !== 1) begin fails++; $display("FAIL dwn_stop: got %0d want 1", n_stop); end
        frame();
        frame();
        tests++; if (frame_cnt !== 32'd0) begin fails++; $display("FAIL dwn_hold: got %0d want 0", frame_cnt); end
        dwn = 1'b0;
        frame();
        tests++; if (frame_cnt !== 32'd1 || state !== 2'd0 || n_start !== 0) begin fails++; $display("FAIL dwn_rearm: got fc=%0d st=%0d starts=%0d want 1/0/0", frame_cnt, state, n_start); end
    endtask

    task automatic test_disarm_races();
        do_reset();
        arm = 1'b1;
        disarm = 1'b1;
        tick();
        {arm, disarm} = '0;
        tick();
        tests++; if (state !== 2'd0) begin fails++; $display("FAIL race_arm_disarm: got %0d want 0", state); end
        arm_pulse(32'd0, 4'd0, 16'd3);
        vs = 1'b1;
        tick();
        tick();
        vs = 1'b0;
        disarm = 1'b1;
        tick();
        disarm = 1'b0;
        tick();
        tick();
        tests++; if (state !== 2'd0 || n_start !== 0 || dump_en !== 1'b0) begin fails++; $display("FAIL race_fall_disarm: got st=%0d starts=%0d en=%b want 0/0/0", state, n_start, dump_en); end
        tests++; if (frame_cnt !== 32'd1) begin fails++; $display("FAIL race_cnt: got %0d want 1", frame_cnt); end
    endtask

    task automatic test_async_reset();
        do_reset();
        arm_pulse(32'd0, 4'd0, 16'd0);
        frame();
        clr_mon();
        rst_n = 1'b0;
        #1;
        tests++; if (dump_en !== 1'b0 || state !== 2'd0) begin fails++; $display("FAIL areset_drop: got en=%b st=%0d want 0/0", dump_en, state); end
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        tests++; if (n_stop !== 0) begin fails++; $display("FAIL areset_nostop: got %0d want 0", n_stop); end
    endtask

    initial begin
        test_reset();
        test_count();
        test_window();
        test_unlimited();
        test_wrap();
        test_dwn();
        test_disarm_races();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/jtframe_dump_trig.md
# jtframe_dump_trig

Synthesizable frame counter and dump-window trigger that drives the frame_cnt/VGA_VS side of the simulation dump controller. It counts falling edges of vertical sync, holds the count at zero during ROM download, and, once armed, asserts a dump window that opens on a programmed frame and closes after a programmed number of frames. It sits in the game top beside the video timing generator. Its frame_cnt and dump_en outputs feed both the waveform dumper and on-chip debug capture.

## Interface
Parameters:
- CW, 32, frame counter width
- LW, 16, window length width

Ports:
- clk  in  1  system clock. One clock domain only.
- rst_n  in  1  asynchronous, active-low reset
- vs  in  1  vertical sync, synchronous to clk; a frame ends on its falling edge
- dwn  in  1  ROM download in progress (LED signal). High holds the counter at 0.
- arm  in  1  single-cycle pulse; latches start_frame/len and arms the trigger
- disarm  in  1  single-cycle pulse; aborts the trigger from any state
- start_frame  in  CW  frame number on whose ending edge the window opens
- len  in  LW  window length in frames; 0 = unlimited
- frame_cnt  out  CW  completed-frame count
- dump_en  out  1  high while the window is open
- dump_start  out  1  one-cycle pulse when the window opens
- dump_stop  out  1  one-cycle pulse when the window closes
- state  out  2  current FSM state, for debug

## Operation
- Edge detect: vs_l is the registered vs, reset to 0. fall = vs_l & ~vs. No fall is possible in the first cycle after reset.
- Counter behaviour:
  - dwn high: frame_cnt is forced to 0 and falls are ignored.
  - Otherwise each fall increments frame_cnt by 1, modulo 2^CW. All-ones wraps to 0.
- FSM states: IDLE=0, ARMED=1, ACTIVE=2, DONE=3.
  - IDLE or DONE: arm → ARMED. start_frame and len are latched into st_r and len_r.
  - ARMED: a fall with frame_cnt (pre-increment value) == st_r → ACTIVE. dump_en rises, dump_start pulses, and the remaining-frames counter rem is loaded with len_r.
  - ACTIVE, len_r ≠ 0: each fall decrements rem. When a fall occurs with rem == 1 → DONE. dump_en falls and dump_stop pulses.
  - ACTIVE, len_r == 0: remains ACTIVE until disarm or dwn.
  - arm in ARMED or ACTIVE is ignored.
- Boundary rules:
  - disarm in any state → IDLE. If the FSM was ACTIVE, dump_stop pulses.
  - disarm and arm in the same cycle: disarm wins.
  - dwn high in ARMED or ACTIVE → IDLE, with dump_stop if the FSM was ACTIVE. The trigger must be re-armed after download.
  - st_r below the current frame_cnt: the trigger waits for counter wrap-around. It does not fire early.
  - Simultaneous fall and disarm: disarm wins and no dump_start is issued.
- Reset values: frame_cnt=0, dump_en=0, dump_start=0, dump_stop=0, state=IDLE, st_r=0, len_r=0, rem=0, vs_l=0.
- A reset mid-window drops dump_en immediately (asynchronously) and issues no dump_stop.

## Timing
- vs is sampled low at edge N while vs_l=1, so fall is true during cycle N. At edge N+1:
  - frame_cnt updates;
  - state, dump_en and dump_start/dump_stop update.
  - Latency from the vs sample to the outputs is one clock.
- dump_start and dump_stop are exactly one clock wide and are never high together.
- A window of len=L spans exactly L falls: from the opening edge up to the L-th subsequent fall, which closes it.
- arm takes effect at the next edge. A fall in the same cycle as arm is not compared.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Structure
- Shared package jtframe_dump_pkg:
  - state encoding constants DT_IDLE, DT_ARMED, DT_ACTIVE, DT_DONE;
  - default CW/LW.
- Sub-module jtframe_dump_edge: vs registration and fall detection with the reset-to-0 rule. It is reused by other frame-synchronous debug blocks.
- The counter, FSM and latches live in the top module.

## Test plan
- Reset, then 5 vs pulses with dwn=0 → frame_cnt=5. No pulse outputs and state=IDLE throughout.
- arm with start_frame=3, len=2 at frame_cnt=0 → dump_start one cycle after the fall ending frame 3. dump_en stays high for 2 falls. dump_stop follows the fall ending frame 5, and state=DONE.
- Same as above with len=0 → dump_en stays high for 10+ frames. A disarm then yields dump_stop, dump_en=0 and state=IDLE.
- Preload frame_cnt near 2^CW-1 (small-CW build, CW=4). Arm with start_frame=1 at frame_cnt=14 → frame_cnt wraps 15→0. The window opens on the fall ending frame 1.
- Assert dwn during ACTIVE → frame_cnt=0, dump_stop pulse, state=IDLE. Falls during dwn do not count.
- arm and disarm in the same cycle, and separately a fall coinciding with disarm while ARMED at the matching frame → state=IDLE and no dump_start in either case.
